// File: rtl/ofs_plat_host_chan_align_pkg.sv
// Shared types and helpers for the host-channel TX TLP aligner.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package ofs_plat_host_chan_align_pkg;

  // Default bus geometry: PCIe SS 512-bit data path with a 256-bit header.
  localparam int ALIGN_TDATA_WIDTH = 512;
  localparam int ALIGN_HDR_WIDTH   = 256;

  // Widest keep vector the contiguity check can handle (2048-bit tdata).
  localparam int KEEP_MAX = 256;

  typedef enum logic [1:0] {
    SOP   = 2'd0,
    BODY  = 2'd1,
    FLUSH = 2'd2
  } t_align_state;

  // Payload bits that fit in a beat after the header (D).
  function automatic int data_bits_after_hdr(input int tdata_w, input int hdr_w);
    return tdata_w - hdr_w;
  endfunction

  // Payload bytes that fit in a beat after the header (DK).
  function automatic int data_bytes_after_hdr(input int tdata_w, input int hdr_w);
    return (tdata_w - hdr_w) / 8;
  endfunction

  // Header bytes (HK).
  function automatic int hdr_bytes(input int hdr_w);
    return hdr_w / 8;
  endfunction

  // A keep is contiguous from bit 0 when it has the form 2^k-1, i.e. adding
  // one carries through every set bit and leaves nothing in common with it.
  function automatic logic keep_is_contiguous(input logic [KEEP_MAX-1:0] keep);
    return (keep & (keep + KEEP_MAX'(1))) == '0;
  endfunction

endpackage

// File: rtl/ofs_plat_host_chan_align_skid.sv
// Two-entry skid buffer with a registered head, generic payload width.
// Latency: 1 cycle from input accept to out_vld_o.
// Backpressure: in_rdy_o drops only when both entries are held; sustains one beat per cycle.
module ofs_plat_host_chan_align_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [WIDTH-1:0] out_dat_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic             push;
  logic             pop;

  assign in_rdy_o  = (cnt_q != 2'd2);
  assign out_vld_o = (cnt_q != 2'd0);
  assign out_dat_o = mem_q[rd_ptr_q];

  assign push  = in_vld_i && in_rdy_o;
  assign pop   = out_vld_o && out_rdy_i;
  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

  // Occupancy and pointer bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Payload storage; the head entry is never overwritten while it is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_dat_i;
  end

endmodule

// File: rtl/ofs_plat_host_chan_align_tx_tlps_gen.sv
// Merges out-of-band PCIe SS headers with raw TLP payload into an in-band, header-aligned TLP stream.
// Latency: 1 cycle input accept to out_tvalid with OUT_REG=1, 0 cycles with OUT_REG=0.
// Backpressure: inputs accepted only when the output stage can take a beat; header and first data beat accepted together.
module ofs_plat_host_chan_align_tx_tlps_gen
  import ofs_plat_host_chan_align_pkg::*;
#(
  parameter int TDATA_WIDTH = ALIGN_TDATA_WIDTH,
  parameter int HDR_WIDTH   = ALIGN_HDR_WIDTH,
  parameter int OUT_REG     = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,

  input  logic                     hdr_tvalid,
  output logic                     hdr_tready,
  input  logic [HDR_WIDTH-1:0]     hdr_tdata,
  input  logic                     hdr_dm_mode,
  input  logic                     hdr_has_data,

  input  logic                     data_tvalid,
  output logic                     data_tready,
  input  logic [TDATA_WIDTH-1:0]   data_tdata,
  input  logic [TDATA_WIDTH/8-1:0] data_tkeep,
  input  logic                     data_tlast,

  output logic                     out_tvalid,
  input  logic                     out_tready,
  output logic [TDATA_WIDTH-1:0]   out_tdata,
  output logic [TDATA_WIDTH/8-1:0] out_tkeep,
  output logic                     out_tlast,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     out_dm_mode,

  output logic                     err_keep_gap,
  output logic [CNT_WIDTH-1:0]     tlp_count
);

  localparam int D  = data_bits_after_hdr(TDATA_WIDTH, HDR_WIDTH);
  localparam int DK = data_bytes_after_hdr(TDATA_WIDTH, HDR_WIDTH);
  localparam int HK = hdr_bytes(HDR_WIDTH);
  localparam int KW = TDATA_WIDTH / 8;

  typedef struct packed {
    logic                   dm_mode;
    logic                   sop;
    logic                   last;
    logic [KW-1:0]          keep;
    logic [TDATA_WIDTH-1:0] data;
  } t_beat;

  localparam int BEAT_W = $bits(t_beat);

  t_align_state         state_q;
  logic [HDR_WIDTH-1:0] res_q;
  logic [HK-1:0]        res_keep_q;
  logic                 live_q;
  logic                 err_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  logic  rdy;
  logic  hdr_offer;
  logic  body_offer;
  logic  flush_offer;
  logic  beat_offer;
  logic  beat_go;
  logic  data_go;
  logic  gap;
  t_beat beat;
  t_beat out_beat;
  logic  out_vld;

  // Work out which transfer the current state could make, ignoring the sink.
  // live_q keeps every ready low while reset is held.
  always_comb begin
    hdr_offer   = live_q && (state_q == SOP) && hdr_tvalid && (!hdr_has_data || data_tvalid);
    body_offer  = live_q && (state_q == BODY) && data_tvalid;
    flush_offer = live_q && (state_q == FLUSH);
  end

  assign beat_offer  = hdr_offer || body_offer || flush_offer;
  assign beat_go     = beat_offer && rdy;
  assign data_go     = rdy && (body_offer || (hdr_offer && hdr_has_data));
  assign hdr_tready  = hdr_offer && rdy;
  assign data_tready = data_go;
  assign gap         = !keep_is_contiguous(KEEP_MAX'(data_tkeep));

  // Assemble the outgoing beat: header or carried residue low, fresh payload high.
  // A set residue keep byte 0 means the tail spills into one more beat.
  always_comb begin
    beat = '0;
    case (state_q)
      SOP: begin
        beat.sop                  = 1'b1;
        beat.dm_mode              = hdr_dm_mode;
        beat.data[HDR_WIDTH-1:0]  = hdr_tdata;
        beat.keep[HK-1:0]         = '1;
        if (hdr_has_data) begin
          beat.data[HDR_WIDTH +: D] = data_tdata[D-1:0];
          beat.keep[HK +: DK]       = data_tkeep[DK-1:0];
          beat.last                 = data_tlast && !data_tkeep[DK];
        end else begin
          beat.last = 1'b1;
        end
      end
      BODY: begin
        beat.data[HDR_WIDTH-1:0]  = res_q;
        beat.data[HDR_WIDTH +: D] = data_tdata[D-1:0];
        beat.keep[HK-1:0]         = res_keep_q;
        beat.keep[HK +: DK]       = data_tkeep[DK-1:0];
        beat.last                 = data_tlast && !data_tkeep[DK];
      end
      FLUSH: begin
        beat.data[HDR_WIDTH-1:0] = res_q;
        beat.keep[HK-1:0]        = res_keep_q;
        beat.last                = 1'b1;
      end
      default: beat = '0;
    endcase
  end

  // Alignment FSM with residue capture and keep-gap flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SOP;
      res_q      <= '0;
      res_keep_q <= '0;
      live_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      live_q <= 1'b1;
      err_q  <= data_go && gap;
      if (data_go) begin
        res_q      <= data_tdata[D +: HDR_WIDTH];
        res_keep_q <= data_tkeep[DK +: HK];
      end
      if (beat_go) begin
        case (state_q)
          SOP, BODY: begin
            if (data_go) begin
              if (!data_tlast)        state_q <= BODY;
              else if (data_tkeep[DK]) state_q <= FLUSH;
              else                    state_q <= SOP;
            end
          end
          FLUSH:   state_q <= SOP;
          default: state_q <= SOP;
        endcase
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_skid
      logic skid_rdy;

      ofs_plat_host_chan_align_skid #(
        .WIDTH (BEAT_W)
      ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_vld_i  (beat_offer),
        .in_rdy_o  (skid_rdy),
        .in_dat_i  (beat),
        .out_vld_o (out_vld),
        .out_rdy_i (out_tready),
        .out_dat_o (out_beat)
      );

      assign rdy = skid_rdy;
    end else begin : g_comb
      assign out_vld  = beat_offer;
      assign out_beat = beat;
      assign rdy      = out_tready;
    end
  endgenerate

  assign out_tvalid  = out_vld;
  assign out_tdata   = out_beat.data;
  assign out_tkeep   = out_beat.keep;
  assign out_tlast   = out_beat.last;
  assign out_eop     = out_beat.last;
  assign out_sop     = out_beat.sop;
  assign out_dm_mode = out_beat.dm_mode;

  assign cnt_d = cnt_q + CNT_WIDTH'(1);

  // Count TLPs as their last beat leaves; wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (out_vld && out_tready && out_beat.last) begin
      cnt_q <= cnt_d;
    end
  end

  assign err_keep_gap = err_q;
  assign tlp_count    = cnt_q;

endmodule

// File: tb/tb_ofs_plat_host_chan_align_tx_tlps_gen.sv
module tb_ofs_plat_host_chan_align_tx_tlps_gen;

  localparam int TW = 512;
  localparam int HW = 256;
  localparam int KW = TW / 8;

  typedef logic [TW-1:0] dat_t;
  typedef logic [KW-1:0] kp_t;
  typedef struct {
    dat_t d;
    kp_t  k;
    logic last;
    logic sop;
    logic dm;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          hdr_tvalid = 1'b0;
  logic          hdr_tready;
  logic [HW-1:0] hdr_tdata = '0;
  logic          hdr_dm_mode = 1'b0;
  logic          hdr_has_data = 1'b0;
  logic          data_tvalid = 1'b0;
  logic          data_tready;
  dat_t          data_tdata = '0;
  kp_t           data_tkeep = '0;
  logic          data_tlast = 1'b0;
  logic          out_tvalid;
  logic          out_tready = 1'b1;
  dat_t          out_tdata;
  kp_t           out_tkeep;
  logic          out_tlast, out_sop, out_eop, out_dm_mode, err_keep_gap;
  logic [31:0]   tlp_count;

  // Narrow-counter twin: same inputs, used to observe counter wrap.
  logic          o2_hdr_tready, o2_data_tready, o2_tvalid, o2_tlast, o2_sop, o2_eop, o2_dm, o2_err;
  dat_t          o2_tdata;
  kp_t           o2_tkeep;
  logic [1:0]    tlp_count2;

  int   checks = 0;
  int   errors = 0;
  int   sent = 0;
  int   rmode = 0;
  exp_t expq[$];
  dat_t bd[8];
  kp_t  bk[8];
  int   nb = 0;

  `define CHK(TAG, OBS, EXP) begin checks++; assert ((OBS) === (EXP)) else begin errors++; $error("FAIL %s: observed=%0h expected=%0h", TAG, OBS, EXP); end end

  always #5 clk = ~clk;

  ofs_plat_host_chan_align_tx_tlps_gen #(
    .TDATA_WIDTH(TW), .HDR_WIDTH(HW), .OUT_REG(1), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .hdr_tvalid(hdr_tvalid), .hdr_tready(hdr_tready), .hdr_tdata(hdr_tdata),
    .hdr_dm_mode(hdr_dm_mode), .hdr_has_data(hdr_has_data),
    .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tdata(data_tdata),
    .data_tkeep(data_tkeep), .data_tlast(data_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tlast(out_tlast), .out_sop(out_sop), .out_eop(out_eop),
    .out_dm_mode(out_dm_mode), .err_keep_gap(err_keep_gap), .tlp_count(tlp_count)
  );

  ofs_plat_host_chan_align_tx_tlps_gen #(
    .TDATA_WIDTH(TW), .HDR_WIDTH(HW), .OUT_REG(1), .CNT_WIDTH(2)
  ) dut2 (
    .clk(clk), .reset_n(reset_n),
    .hdr_tvalid(hdr_tvalid), .hdr_tready(o2_hdr_tready), .hdr_tdata(hdr_tdata),
    .hdr_dm_mode(hdr_dm_mode), .hdr_has_data(hdr_has_data),
    .data_tvalid(data_tvalid), .data_tready(o2_data_tready), .data_tdata(data_tdata),
    .data_tkeep(data_tkeep), .data_tlast(data_tlast),
    .out_tvalid(o2_tvalid), .out_tready(out_tready), .out_tdata(o2_tdata),
    .out_tkeep(o2_tkeep), .out_tlast(o2_tlast), .out_sop(o2_sop), .out_eop(o2_eop),
    .out_dm_mode(o2_dm), .err_keep_gap(o2_err), .tlp_count(tlp_count2)
  );

  // Keep is legal when no byte is disabled below an enabled one.
  function automatic bit contig(input kp_t k);
    bit seen0 = 1'b0;
    for (int i = 0; i < KW; i++) begin
      if (!k[i]) seen0 = 1'b1;
      else if (seen0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic set_payload(input int len);
    nb = (len + 63) / 64;
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < KW; i++) begin
        bd[b][8*i +: 8] = 8'($urandom);
        bk[b][i]        = (64*b + i) < len;
      end
  endtask

  task automatic rand_hdr(output logic [HW-1:0] h);
    for (int i = 0; i < HW/32; i++) h[32*i +: 32] = $urandom;
  endtask

  // Reference: the TLP is a byte stream of 32 header bytes followed by every
  // payload byte slot, cut into 64-byte output beats; a trailing beat that
  // would carry no enabled byte is not emitted.
  task automatic model_push(input logic [HW-1:0] h, input logic dm, input logic has);
    logic [7:0] sb[$];
    bit         sk[$];
    int         n;
    bit         any;
    exp_t       e;
    for (int i = 0; i < HW/8; i++) begin sb.push_back(h[8*i +: 8]); sk.push_back(1'b1); end
    if (has)
      for (int b = 0; b < nb; b++)
        for (int i = 0; i < KW; i++) begin sb.push_back(bd[b][8*i +: 8]); sk.push_back(bk[b][i]); end
    n = (sb.size() + 63) / 64;
    any = 1'b0;
    for (int i = 64*(n-1); i < sb.size(); i++) if (sk[i]) any = 1'b1;
    if (!any) n--;
    for (int c = 0; c < n; c++) begin
      e.d = '0;
      e.k = '0;
      for (int i = 0; i < KW; i++) begin
        int idx = 64*c + i;
        if (idx < sb.size()) begin e.d[8*i +: 8] = sb[idx]; e.k[i] = sk[idx]; end
      end
      e.sop  = (c == 0);
      e.last = (c == n - 1);
      e.dm   = (c == 0) ? dm : 1'b0;
      expq.push_back(e);
    end
    sent++;
  endtask

  task automatic drive_beat(input int b);
    data_tvalid = 1'b1;
    data_tdata  = bd[b];
    data_tkeep  = bk[b];
    data_tlast  = (b == nb - 1);
  endtask

  // Called at a negedge; waits for the handshake the next posedge will take.
  task automatic wait_ready(input bit need_hdr, input bit has, output bit ok);
    int w = 0;
    ok = 1'b1;
    while (!(need_hdr ? (hdr_tready && (!has || data_tready)) : data_tready)) begin
      w++;
      if (w > 400) begin
        checks++; errors++;
        $error("FAIL handshake_timeout: observed=no_ready expected=ready_within_400");
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_tlp(input logic [HW-1:0] h, input logic dm, input logic has);
    bit ok;
    model_push(h, dm, has);
    @(posedge clk); #1;
    hdr_tvalid = 1'b1; hdr_tdata = h; hdr_dm_mode = dm; hdr_has_data = has;
    if (has) drive_beat(0);
    @(negedge clk);
    for (int b = 0; b < (has ? nb : 1); b++) begin
      wait_ready(b == 0, has, ok);
      if (!ok) begin hdr_tvalid = 1'b0; data_tvalid = 1'b0; return; end
      @(posedge clk); #1;
      hdr_tvalid = 1'b0;
      if (has && b + 1 < nb) drive_beat(b + 1);
      else data_tvalid = 1'b0;
      @(negedge clk);
      if (has) `CHK("err_keep_gap_at_accept", err_keep_gap, !contig(bk[b]))
    end
  endtask

  task automatic drain();
    int w = 0;
    while (expq.size() != 0 && w < 600) begin @(negedge clk); w++; end
    if (expq.size() != 0) begin
      checks++; errors++;
      $error("FAIL drain_timeout: observed=%0d pending expected=0", expq.size());
    end
    @(posedge clk); @(negedge clk);
    `CHK("tlp_count", tlp_count, 32'(sent))
    `CHK("tlp_count_wrap2", tlp_count2, 2'(sent))
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HW-1:0] h;
    bit ok;

    // Sink ready driver and output monitor run alongside the directed steps.
    fork
      forever begin
        @(posedge clk); #1;
        case (rmode)
          0:       out_tready = 1'b1;
          1:       out_tready = ~out_tready;
          default: out_tready = 1'b0;
        endcase
      end
      begin : mon
        bit   stall = 1'b0;
        dat_t hd;
        kp_t  hk;
        logic hl;
        exp_t e;
        forever begin
          @(negedge clk);
          if (!reset_n) begin
            stall = 1'b0;
          end else begin
            if (stall) begin
              `CHK("stall_valid_held", out_tvalid, 1'b1)
              `CHK("stall_data_held", out_tdata, hd)
              `CHK("stall_keep_held", out_tkeep, hk)
              `CHK("stall_last_held", out_tlast, hl)
            end
            if (out_tvalid && out_tready) begin
              if (expq.size() == 0) begin
                checks++; errors++;
                $error("FAIL unexpected_beat: observed=%0h expected=no_beat", out_tdata);
              end else begin
                e = expq.pop_front();
                `CHK("beat_data", out_tdata, e.d)
                `CHK("beat_keep", out_tkeep, e.k)
                `CHK("beat_last", out_tlast, e.last)
                `CHK("beat_eop", out_eop, e.last)
                `CHK("beat_sop", out_sop, e.sop)
                `CHK("beat_dm", out_dm_mode, e.dm)
              end
            end
            stall = out_tvalid && !out_tready;
            hd = out_tdata; hk = out_tkeep; hl = out_tlast;
          end
        end
      end
    join_none

    // Reset state, with valid inputs offered that must not be taken.
    hdr_tvalid = 1'b1; hdr_has_data = 1'b0; data_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    `CHK("reset_out_tvalid", out_tvalid, 1'b0)
    `CHK("reset_hdr_tready", hdr_tready, 1'b0)
    `CHK("reset_data_tready", data_tready, 1'b0)
    `CHK("reset_err_keep_gap", err_keep_gap, 1'b0)
    `CHK("reset_tlp_count", tlp_count, 32'd0)
    @(posedge clk); #1;
    hdr_tvalid = 1'b0; data_tvalid = 1'b0; reset_n = 1'b1;
    repeat (3) @(negedge clk);
    `CHK("idle_out_tvalid", out_tvalid, 1'b0)

    // Header-only TLP.
    rand_hdr(h); send_tlp(h, 1'b1, 1'b0); drain();
    // 32-byte payload: single output beat.
    rand_hdr(h); set_payload(32); send_tlp(h, 1'b0, 1'b1); drain();
    // 64-byte payload: second beat carries the residue.
    rand_hdr(h); set_payload(64); send_tlp(h, 1'b1, 1'b1); drain();
    // Multi-beat payloads with sink ready toggling every cycle.
    rmode = 1;
    rand_hdr(h); set_payload(160); send_tlp(h, 1'b0, 1'b1); drain();
    rand_hdr(h); set_payload(176); send_tlp(h, 1'b1, 1'b1); drain();
    rmode = 0;

    // Non-contiguous keep: flagged for exactly one cycle, data passes through.
    rand_hdr(h); set_payload(64); bk[0] = 64'h0F0F;
    send_tlp(h, 1'b0, 1'b1);
    @(negedge clk);
    `CHK("err_keep_gap_one_cycle", err_keep_gap, 1'b0)
    drain();

    // Randomized TLP mix; the narrow counter wraps along the way.
    for (int t = 0; t < 30; t++) begin
      rmode = $urandom_range(0, 1);
      rand_hdr(h);
      set_payload($urandom_range(1, 300));
      send_tlp(h, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    rmode = 0;
    drain();

    // Reset in the middle of a 3-beat TLP held back by the sink.
    rmode = 2;
    repeat (2) @(posedge clk);
    rand_hdr(h); set_payload(160);
    @(posedge clk); #1;
    hdr_tvalid = 1'b1; hdr_tdata = h; hdr_has_data = 1'b1; hdr_dm_mode = 1'b0;
    drive_beat(0);
    @(negedge clk);
    wait_ready(1'b1, 1'b1, ok);
    @(posedge clk); #1;
    hdr_tvalid = 1'b0;
    drive_beat(1);
    @(negedge clk);
    wait_ready(1'b0, 1'b1, ok);
    @(posedge clk); #1;
    data_tvalid = 1'b0;
    reset_n = 1'b0;
    hdr_tvalid = 1'b1; hdr_has_data = 1'b0;
    expq.delete();
    sent = 0;
    repeat (2) @(negedge clk);
    `CHK("midreset_out_tvalid", out_tvalid, 1'b0)
    `CHK("midreset_hdr_tready", hdr_tready, 1'b0)
    `CHK("midreset_tlp_count", tlp_count, 32'd0)
    `CHK("midreset_tlp_count2", tlp_count2, 2'd0)
    @(posedge clk); #1;
    hdr_tvalid = 1'b0;
    reset_n = 1'b1;
    rmode = 0;
    repeat (3) @(negedge clk);
    `CHK("postreset_no_output", out_tvalid, 1'b0)
    rand_hdr(h); set_payload(32); send_tlp(h, 1'b1, 1'b1); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
